// File: rtl/sweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
// Holds the FSM state enum plus mode and direction encodings.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: load, stall when en is low, zero flag.
// Ports: clk, rst, load, load_val, en -> zero.
module sweep_dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Command-driven up/down sweep sequencer with dwell, pause, abort.
// Ports: cmd_* handshake in, pause/abort in -> count, busy, done.
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_start,
    input  logic [WIDTH-1:0]   cmd_end,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_mode,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   target_q;
    logic [WIDTH-1:0]   origin_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               dir_q;
    logic               mode_q;
    logic               leg_q;

    logic             accept;
    logic             run;
    logic             at_tgt;
    logic             turn;
    logic             step;
    logic             finish;
    logic             dwell_zero;
    logic             step_dir;
    logic [WIDTH-1:0] step_val;

    assign accept = (state_q == IDLE) && cmd_valid;
    assign run    = (state_q == HOLD) && !pause && !abort;
    assign at_tgt = (count_q == target_q);

    // Bounce turnaround: only on the first leg and only if there
    // is somewhere to go back to.
    assign turn   = (mode_q == MODE_BOUNCE) && !leg_q
                    && (origin_q != target_q);
    assign step   = run && dwell_zero && (!at_tgt || turn);
    assign finish = run && dwell_zero && at_tgt && !turn;

    // At the turnaround the step already heads back toward origin,
    // so the end value is not repeated.
    assign step_dir = at_tgt ? ~dir_q : dir_q;
    assign step_val = (step_dir == DIR_UP) ? count_q + ONE
                                           : count_q - ONE;

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (accept || step),
        .load_val (accept ? cmd_dwell : dwell_q),
        .en       (run),
        .zero     (dwell_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == HOLD);
        done      = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            target_q <= '0;
            origin_q <= '0;
            dwell_q  <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= MODE_SINGLE;
            leg_q    <= 1'b0;
        end else if (accept) begin
            count_q  <= cmd_start;
            target_q <= cmd_end;
            origin_q <= cmd_start;
            dwell_q  <= cmd_dwell;
            dir_q    <= (cmd_end >= cmd_start) ? DIR_UP : DIR_DOWN;
            mode_q   <= cmd_mode;
            leg_q    <= 1'b0;
        end else if (step) begin
            count_q <= step_val;
            if (at_tgt) begin
                target_q <= origin_q;
                dir_q    <= ~dir_q;
                leg_q    <= 1'b1;
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl.
// Sequence-list model plus directed literal expectations.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_start = '0;
    logic [7:0] cmd_end = '0;
    logic [3:0] cmd_dwell = '0;
    logic       cmd_mode = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    updown_sweep_ctrl #(
        .WIDTH   (8),
        .DWELL_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_dwell (cmd_dwell),
        .cmd_mode  (cmd_mode),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: the whole sweep is a list of per-cycle values; each
    // unpaused HOLD cycle consumes one entry.
    int q[$];
    int m_count = 0;
    bit m_busy = 0;
    bit m_done = 0;

    task automatic build_seq(input int s, input int e,
                             input int d, input bit bounce);
        int vals[$];
        int stp;
        stp = (e >= s) ? 1 : -1;
        for (int v = s; v != e; v += stp) vals.push_back(v);
        vals.push_back(e);
        if (bounce && (e != s)) begin
            for (int v = e - stp; v != s; v -= stp) vals.push_back(v);
            vals.push_back(s);
        end
        q.delete();
        foreach (vals[i])
            for (int k = 0; k <= d; k++) q.push_back(vals[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_count = 0;
                m_busy = 0;
                m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (abort) begin
                    m_busy = 0;
                    q.delete();
                end else if (!pause) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_count = q[0];
                    end
                end
            end else if (cmd_valid) begin
                build_seq(int'(cmd_start), int'(cmd_end),
                          int'(cmd_dwell), cmd_mode);
                m_count = q[0];
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_count", int'(count), m_count);
            chk("m_busy", int'(busy), int'(m_busy));
            chk("m_done", int'(done), int'(m_done));
            chk("m_ready", int'(cmd_ready), int'(!m_busy && !m_done));
        end
    end

    task automatic send(input int s, input int e,
                        input int d, input bit md);
        @(negedge clk);
        cmd_start = 8'(s);
        cmd_end   = 8'(e);
        cmd_dwell = 4'(d);
        cmd_mode  = md;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int dc;
        int c2;
        int pl;
        bit st;
        bit ok;
        bit z;
        int vals[$];

        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 3->6, D=0, single
        send(3, 6, 0, 0);
        chk("t1_c0", int'(count), 3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t1_cnt", int'(count), 3 + i);
        end
        @(negedge clk);
        chk("t1_done", int'(done), 1);
        @(negedge clk);
        chk("t1_ready", int'(cmd_ready), 1);
        chk("t1_done_off", int'(done), 0);

        // 10->7, D=2, single
        send(10, 7, 2, 0);
        bc = busy ? 1 : 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
            if (busy) bc++;
        end
        chk("t2_to", int'(ok), 1);
        dc = 1;
        repeat (3) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("t2_busy", bc, 12);
        chk("t2_dones", dc, 1);

        // 254->255, bounce
        send(254, 255, 0, 1);
        vals.delete();
        vals.push_back(int'(count));
        z = (count == 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
            if (busy) vals.push_back(int'(count));
            if (count == 0) z = 1;
        end
        chk("t3_to", int'(ok), 1);
        chk("t3_len", vals.size(), 3);
        if (vals.size() == 3) begin
            chk("t3_v0", vals[0], 254);
            chk("t3_v1", vals[1], 255);
            chk("t3_v2", vals[2], 254);
        end
        @(negedge clk);
        if (count == 0) z = 1;
        chk("t3_zero", int'(z), 0);

        // 0->4, D=1, pause 3 cycles at count 2
        send(0, 4, 1, 0);
        bc = busy ? 1 : 0;
        c2 = 0;
        pl = 0;
        st = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
            if (busy) bc++;
            if (busy && count == 2) c2++;
            if (pl > 0) begin
                pl--;
                if (pl == 0) pause = 1'b0;
            end else if (c2 == 1 && !st) begin
                pause = 1'b1;
                pl = 3;
                st = 1;
            end
        end
        pause = 1'b0;
        chk("t4_to", int'(ok), 1);
        chk("t4_busy", bc, 13);
        chk("t4_hold2", c2, 5);
        @(negedge clk);

        // 0->9 abort at 5
        send(0, 9, 0, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (count == 5) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("t5_reach5", int'(ok), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_ready", int'(cmd_ready), 1);
        chk("t5_hold", int'(count), 5);
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("t5_nodone", dc, 0);
        send(0, 9, 0, 0);
        chk("t5_acc_busy", int'(busy), 1);
        chk("t5_acc_cnt", int'(count), 0);
        cmd_start = 8'd100;
        cmd_end   = 8'd120;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = (i % 2 == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        chk("t5_to", int'(ok), 1);
        repeat (2) @(negedge clk);
        chk("t5_idle", int'(busy), 0);
        chk("t5_final", int'(count), 9);

        // 0->9, async reset mid-sweep
        send(0, 9, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_count", int'(count), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cmd_ready), 1);
        chk("t6_done", int'(done), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
